dual_debounce: RTL
==================

Name: dual_debounce

Overview:
- Two-channel input conditioner that sits directly upstream of and_gate. Its outputs drive and_gate's a/b inputs.
- Each raw, asynchronous input (switch or button) is synchronized with a 2-flop synchronizer and then filtered by a per-channel debounce FSM.
- A channel's clean output changes only after the new level has been held for DEBOUNCE_CYCLES consecutive clocks.
- The block gives and_gate and its testbenches glitch-free, clock-aligned stimulus.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable clocks required before an output changes. Legal range 1..255.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): width of the per-channel counter. Derived; do not override.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_raw  input  1  raw channel A input, asynchronous to clk.
- b_raw  input  1  raw channel B input, asynchronous to clk.
- a  output  1  debounced channel A; connects to and_gate.a.
- b  output  1  debounced channel B; connects to and_gate.b.
- a_busy  output  1  high while channel A is in a WAIT state (candidate change being qualified).
- b_busy  output  1  high while channel B is in a WAIT state.

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - sync flops = 0, counters = 0, both FSMs in ST_LOW.
  - a = b = 0; a_busy = b_busy = 0.
  - Release is synchronous in effect: the first state update happens on the first rising edge with rst_n high.
- Synchronizer: two flops per channel; the second flop is s_q. s_q reflects a raw level 2 clocks after it is sampled.
- Per-channel FSM states: ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW.
  - ST_LOW: out = 0. If s_q = 1, go to WAIT_HIGH with cnt = 1.
  - WAIT_HIGH: out = 0, busy = 1.
    - If s_q = 0, return to ST_LOW and clear cnt (glitch rejected).
    - Else if cnt == DEBOUNCE_CYCLES, go to ST_HIGH and clear cnt.
    - Else increment cnt.
  - ST_HIGH and WAIT_LOW mirror ST_LOW and WAIT_HIGH with polarity inverted.
  - Out is registered and equals 1 exactly in ST_HIGH and WAIT_LOW.
- DEBOUNCE_CYCLES = 1 is legal: WAIT lasts one clock.
- Latency:
  - Raw level held steady → output follows DEBOUNCE_CYCLES + 2 clocks after the first sampling edge.
  - 2 cycles synchronizer + DEBOUNCE_CYCLES cycles qualification.
- Glitch rule: a pulse whose synchronized width is ≤ DEBOUNCE_CYCLES - 1 clocks never reaches the output.
- Counter never exceeds DEBOUNCE_CYCLES, so no wrap-around is possible.
- Channels are fully independent. Simultaneous transitions on a_raw and b_raw are qualified in parallel with identical latency.
- Reset asserted mid-WAIT: state, counter and outputs return to reset values immediately. No pending change survives reset.

Optional Feature:
- Macro: DUAL_DEBOUNCE_EDGE_EN.
- Defined: adds outputs a_rise, a_fall, b_rise, b_fall, each 1 bit.
  - Each is a registered single-cycle pulse asserted in the same cycle the corresponding debounced output changes.
  - All four reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package dual_debounce_pkg holds:
  - FSM state encoding: ST_LOW = 2'd0, WAIT_HIGH = 2'd1, ST_HIGH = 2'd2, WAIT_LOW = 2'd3.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module debounce_ch: one synchronizer + FSM + counter (+ edge pulses under the macro).
  - Ports: clk, rst_n, raw, out, busy.
  - Instantiated twice; the top is wiring only.
- Build with iverilog -g2012.

Test Plan (DEBOUNCE_CYCLES = 4, 10 ps clock period):
- Reset: rst_n = 0 with a_raw = b_raw = 1 → a = b = 0 and busy = 0 throughout reset. After release, a = b = 1 exactly 6 clocks after the first active edge.
- Clean rise on A: a_raw 0→1 before edge k, held → a_busy = 1 from edge k+2, a = 1 at edge k+6. b stays 0. Downstream and_gate c stays 0.
- Glitch rejection: a_raw high for 3 clocks, then low → a never rises. a_busy pulses, then returns to 0. Counter is back at 0.
- Simultaneous change: a_raw and b_raw 0→1 on the same cycle → a and b rise on the same edge. and_gate c goes 1 one delta later. Then both fall together → c returns to 0 after 6 clocks.
- Mid-operation reset: a_raw rises, and rst_n is pulsed low at edge k+4 for 1 clock (while in WAIT_HIGH) → a stays 0. Re-qualification restarts from reset release: a = 1 six clocks later.
- With DUAL_DEBOUNCE_EDGE_EN: a rise then fall → exactly one a_rise and one a_fall pulse, each 1 clock wide and aligned with the change of a. No pulses appear on the b_* outputs.

Source files
------------

// File: rtl/dual_debounce_pkg.sv
// dual_debounce shared types: debounce FSM encoding and defaults.
// Edge-pulse outputs are enabled by defining DUAL_DEBOUNCE_EDGE_EN.
package dual_debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualify FSM, counter.
// Rise/fall pulses exist only when DUAL_DEBOUNCE_EDGE_EN is defined.
module debounce_ch
  import dual_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic busy
`ifdef DUAL_DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO  = '0;

  logic [1:0] sync_q;
  logic       s_q;
  db_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s_q = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= ST_LOW;
      cnt_q   <= ZERO;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (s_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s_q) begin
          state_d = ST_LOW;
          cnt_d   = ZERO;
        end else if (cnt_q == LIMIT) begin
          state_d = ST_HIGH;
          cnt_d   = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HIGH: begin
        if (!s_q) begin
          state_d = WAIT_LOW;
          cnt_d   = ONE;
        end
      end
      WAIT_LOW: begin
        if (s_q) begin
          state_d = ST_HIGH;
          cnt_d   = ZERO;
        end else if (cnt_q == LIMIT) begin
          state_d = ST_LOW;
          cnt_d   = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = ZERO;
      end
    endcase
  end

  // Encoding puts level in bit 1 and "qualifying" in bit 0.
  assign out  = state_q[1];
  assign busy = state_q[0];

`ifdef DUAL_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state_q == WAIT_HIGH) && (state_d == ST_HIGH);
      fall <= (state_q == WAIT_LOW) && (state_d == ST_LOW);
    end
  end
`endif

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounce channels feeding and_gate a/b.
// Define DUAL_DEBOUNCE_EDGE_EN to add a/b rise and fall pulses.
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_busy,
  output logic b_busy
`ifdef DUAL_DEBOUNCE_EDGE_EN
  ,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
`endif
);

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_ch_a (
    .clk(clk),
    .rst_n(rst_n),
    .raw(a_raw),
    .out(a),
    .busy(a_busy)
`ifdef DUAL_DEBOUNCE_EDGE_EN
    ,
    .rise(a_rise),
    .fall(a_fall)
`endif
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_ch_b (
    .clk(clk),
    .rst_n(rst_n),
    .raw(b_raw),
    .out(b),
    .busy(b_busy)
`ifdef DUAL_DEBOUNCE_EDGE_EN
    ,
    .rise(b_rise),
    .fall(b_fall)
`endif
  );

endmodule
